// File: rtl/ram_pkg.sv
// ram_pkg: shared encodings for the true dual-port byte-enable RAM.
//   RD_FIRST / WR_FIRST : same-port read-during-write modes
//   clr_state_e         : post-reset clear sequencer states
//   be_bits()           : byte-lane count for a given word width
package ram_pkg;

   localparam int RD_FIRST = 0;   // read returns the pre-write word
   localparam int WR_FIRST = 1;   // written lanes return the new bytes

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } clr_state_e;

   function automatic int be_bits(input int data_bits);
      return data_bits / 8;
   endfunction

endpackage

// File: rtl/ram_tdp_rdpipe.sv
// ram_tdp_rdpipe: per-port read output path.
//   Takes the registered array read word (rd_q, valid the cycle after an
//   accepted access) and merges in the port's own written lanes when the
//   RAM runs write-first. RD_LAT=2 adds one output register. A valid bit
//   travels alongside in vld_pipe.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   acc            access accepted this cycle
//   we, din        this port's byte write enables / write data
//   rd_q           array read register (old word)
//   dout, dout_vld read data and its one-cycle valid pulse
module ram_tdp_rdpipe
   import ram_pkg::*;
#(
   parameter int DATA_BITS = 16,
   parameter int BE_BITS   = 2,
   parameter int RD_MODE   = RD_FIRST,
   parameter int RD_LAT    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 acc,
   input  logic [BE_BITS-1:0]   we,
   input  logic [DATA_BITS-1:0] din,
   input  logic [DATA_BITS-1:0] rd_q,
   output logic [DATA_BITS-1:0] dout,
   output logic                 dout_vld
);

   localparam int STAGES = (RD_LAT == 2) ? 2 : 1;

   logic [STAGES:0]      vld_pipe;
   logic [STAGES:1]      vld_q;
   logic [BE_BITS-1:0]   we_q;
   logic [DATA_BITS-1:0] din_q;
   logic [DATA_BITS-1:0] merged;

   assign vld_pipe = {vld_q, acc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_pipe[STAGES-1:0];
   end

   // Lane mask/data captured alongside the array read. In read-first mode the
   // mask is forced to zero so the old word always passes through. Both only
   // load on an accepted access, so dout holds between deliveries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q  <= '0;
         din_q <= '0;
      end else if (acc) begin
         we_q  <= (RD_MODE == WR_FIRST) ? we : '0;
         din_q <= din;
      end
   end

   always_comb begin
      merged = rd_q;
      for (int i = 0; i < BE_BITS; i++)
         if (we_q[i]) merged[i*8 +: 8] = din_q[i*8 +: 8];
   end

   generate
      if (STAGES == 2) begin : g_lat2
         logic [DATA_BITS-1:0] dout_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)          dout_q <= '0;
            else if (vld_pipe[1]) dout_q <= merged;
         end
         assign dout = dout_q;
      end else begin : g_lat1
         assign dout = merged;
      end
   endgenerate

   assign dout_vld = vld_pipe[STAGES];

endmodule

// File: rtl/ram_tdp_be.sv
// ram_tdp_be: parametrised true dual-port RAM with per-byte write enables.
//   Both ports read on every enabled access and write the lanes selected by
//   we. On a same-address double write, port A wins overlapping lanes.
//   A cross-port read of a word being written returns the old word.
//   An optional sequencer writes CLEAR_VAL to every address after reset.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   init_busy                     clear sequence running, requests ignored
//   aen, awe, addra, dia          port A enable / byte we / address / data
//   doa, doa_vld                  port A read data / valid pulse
//   ben, bwe, addrb, dib          port B request
//   dob, dob_vld                  port B read data / valid pulse
//   collision                     same-address conflict pulse (cycle N+1)
module ram_tdp_be
   import ram_pkg::*;
#(
   parameter int                   ADDR_BITS    = 8,
   parameter int                   DATA_BITS    = 16,
   localparam int                  BE_BITS      = be_bits(DATA_BITS),
   parameter int                   RD_MODE      = RD_FIRST,
   parameter int                   RD_LAT       = 1,
   parameter int                   CLEAR_ON_RST = 1,
   parameter logic [DATA_BITS-1:0] CLEAR_VAL    = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 init_busy,
   input  logic                 aen,
   input  logic [BE_BITS-1:0]   awe,
   input  logic [ADDR_BITS-1:0] addra,
   input  logic [DATA_BITS-1:0] dia,
   output logic [DATA_BITS-1:0] doa,
   output logic                 doa_vld,
   input  logic                 ben,
   input  logic [BE_BITS-1:0]   bwe,
   input  logic [ADDR_BITS-1:0] addrb,
   input  logic [DATA_BITS-1:0] dib,
   output logic [DATA_BITS-1:0] dob,
   output logic                 dob_vld,
   output logic                 collision
);

   localparam int               DEPTH = 1 << ADDR_BITS;
   localparam logic [ADDR_BITS:0] LAST = {1'b0, {ADDR_BITS{1'b1}}};
   localparam logic [ADDR_BITS:0] ONE  = {{ADDR_BITS{1'b0}}, 1'b1};

   // ---------------------------------------------------------------- clear FSM
   clr_state_e           state, state_nx;
   logic [ADDR_BITS:0]   cnt, cnt_nx;
   logic                 clr_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      clr_we   = 1'b0;
      case (state)
         ST_CLEAR: begin
            clr_we = 1'b1;
            cnt_nx = cnt + ONE;
            if (cnt == LAST) begin
               state_nx = ST_READY;
               cnt_nx   = '0;
            end
         end
         default: ;
      endcase
   end

   assign init_busy = (state == ST_CLEAR);

   // ---------------------------------------------------------------- access
   logic               rdy, a_acc, b_acc;
   logic [BE_BITS-1:0] a_wr, b_wr;

   assign rdy   = (state == ST_READY);
   assign a_acc = rdy & aen;
   assign b_acc = rdy & ben;
   assign a_wr  = awe & {BE_BITS{a_acc}};
   assign b_wr  = bwe & {BE_BITS{b_acc}};

   // ---------------------------------------------------------------- array
   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [DATA_BITS-1:0] rda_q, rdb_q;

   // Port B lanes are assigned before port A lanes so A's value is the one
   // that lands on an overlapping same-address write.
   always_ff @(posedge clk) begin
      if (clr_we) mem[cnt[ADDR_BITS-1:0]] <= CLEAR_VAL;
      for (int i = 0; i < BE_BITS; i++) begin
         if (b_wr[i]) mem[addrb][i*8 +: 8] <= dib[i*8 +: 8];
         if (a_wr[i]) mem[addra][i*8 +: 8] <= dia[i*8 +: 8];
      end
   end

   // Read registers sample the pre-edge contents: always the old word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rda_q <= '0;
         rdb_q <= '0;
      end else begin
         if (a_acc) rda_q <= mem[addra];
         if (b_acc) rdb_q <= mem[addrb];
      end
   end

   // ---------------------------------------------------------------- collision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) collision <= 1'b0;
      else        collision <= a_acc & b_acc & (addra == addrb) &
                               ((|awe) | (|bwe));
   end

   // ---------------------------------------------------------------- outputs
   ram_tdp_rdpipe #(
      .DATA_BITS (DATA_BITS),
      .BE_BITS   (BE_BITS),
      .RD_MODE   (RD_MODE),
      .RD_LAT    (RD_LAT)
   ) u_pipe_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .acc      (a_acc),
      .we       (a_wr),
      .din      (dia),
      .rd_q     (rda_q),
      .dout     (doa),
      .dout_vld (doa_vld)
   );

   ram_tdp_rdpipe #(
      .DATA_BITS (DATA_BITS),
      .BE_BITS   (BE_BITS),
      .RD_MODE   (RD_MODE),
      .RD_LAT    (RD_LAT)
   ) u_pipe_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .acc      (b_acc),
      .we       (b_wr),
      .din      (dib),
      .rd_q     (rdb_q),
      .dout     (dob),
      .dout_vld (dob_vld)
   );

endmodule

// File: doc/ram_tdp_be.md
Name: ram_tdp_be

Overview:
- Parametrised true dual-port block RAM. Next generation of the team's single-write dual-port RAM, used as the storage for bitonic sort stage buffers.
- Both ports can read and write, with per-byte write enables.
- Selectable read-during-write mode and read latency of 1 or 2, with a valid flag per port.
- Cross-port collision detection, plus an optional post-reset clear sequencer that replaces file-based initialisation.

Parameters:
ADDR_BITS, 8, address width; depth = 2^ADDR_BITS
DATA_BITS, 16, word width; must be a multiple of 8
BE_BITS, DATA_BITS/8, byte-lane count (derived, not overridden)
RD_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (merged new data)
RD_LAT, 1, read latency in cycles; legal values 1 or 2
CLEAR_ON_RST, 1, 1 = write CLEAR_VAL to every address after reset release
CLEAR_VAL, 0, DATA_BITS-wide fill value used by the clear sequencer

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset; affects control and output registers only, never the array directly
init_busy  out  1  high while the clear sequence runs; port requests are ignored while high
aen  in  1  port A access enable
awe  in  BE_BITS  port A byte write enables, qualified by aen
addra  in  ADDR_BITS  port A address
dia  in  DATA_BITS  port A write data
doa  out  DATA_BITS  port A read data
doa_vld  out  1  port A read-data valid pulse
ben, bwe, addrb, dib, dob, dob_vld: same as the port A signals, for port B
collision  out  1  one-cycle pulse on a same-address cross-port conflict

Behaviour:
- Reset values:
  - doa, dob = 0; doa_vld, dob_vld, collision = 0.
  - init_busy = CLEAR_ON_RST.
  - Clear counter = 0.
- Clear FSM states CLEAR and READY; reset enters CLEAR if CLEAR_ON_RST, otherwise READY.
  - CLEAR: each cycle write CLEAR_VAL to address cnt, then cnt++.
  - At cnt = 2^ADDR_BITS-1, do that final write and go to READY the next cycle. init_busy falls in that cycle.
  - The full clear takes exactly 2^ADDR_BITS cycles after rst_n rises.
  - Reset asserted mid-clear: the sequence restarts from address 0 when reset releases.
  - In CLEAR, aen/ben are ignored: no writes, no reads, vld flags stay 0.
- Access (READY):
  - An enabled port always performs a read.
  - Byte lane i is written when en & we[i].
  - awe = 0 is a pure read.
- Latency:
  - RD_LAT=1: data and vld are registered in cycle N+1 for an access in cycle N.
  - RD_LAT=2: one extra output register; data and vld appear in cycle N+2.
  - vld is high for exactly one cycle per accepted access.
  - doX holds its last value when no data is delivered.
  - Back-to-back accesses deliver back-to-back data with no bubbles.
- Same-port read-during-write:
  - RD_MODE 0: doX returns the pre-write word.
  - RD_MODE 1: written lanes return the new bytes; unwritten lanes return the old bytes.
- Cross-port, same address, both enabled, at least one port writing:
  - Both writing, overlapping lanes: port A wins.
  - Both writing, non-overlapping lanes: both ports' lanes land.
  - A read on one port while the other port writes always returns the old word, regardless of RD_MODE.
  - collision pulses in cycle N+1, independent of RD_LAT.
  - Both ports reading the same address is not a collision.
- No arithmetic other than the clear counter. Its width is ADDR_BITS+1 so the terminal count is detected without wrapping.
- Array: a single inferred block-RAM memory; no reset on the array.

Decomposition:
- Shared package ram_pkg holds:
  - the RD_MODE encodings RD_FIRST=0 and WR_FIRST=1;
  - the clear FSM state encodings ST_CLEAR and ST_READY;
  - the BE_BITS derivation function.
- Sub-module ram_tdp_rdpipe contains the per-port output path: lane merge, RD_LAT stage(s) and vld shift register. It is instantiated once for port A and once for port B.
- The clear FSM and the collision compare stay in the top module.

Test Plan (ADDR_BITS=4, DATA_BITS=16):
- Clear: CLEAR_ON_RST=1, CLEAR_VAL=16'hA5A5; release rst_n -> init_busy high for exactly 16 cycles; a read of addr 7 afterwards -> doa=16'hA5A5 with doa_vld 1 cycle later. An aen pulse issued during the clear -> no doa_vld.
- Byte enables and latency: write addr 3 = 16'h1234 (awe=2'b11), then awe=2'b10 with dia=16'hABCD. Read with RD_LAT=1 -> 16'hAB34 in cycle N+1. With RD_LAT=2 -> the same value in cycle N+2, with a single vld pulse.
- Read-during-write: addr 5 holds 16'h0011; port A writes 16'h2200 with awe=2'b10. RD_MODE 0 -> doa=16'h0011. RD_MODE 1 -> doa=16'h2211.
- Collision: same cycle, A writes addr 9 = 16'hFFFF (awe=2'b11), B writes addr 9 = 16'h0000 (awe=2'b01) -> collision=1 for one cycle; a later read of addr 9 returns 16'hFFFF. A 2-port read of the same address -> collision stays 0.
- Cross-port read: addr 2 holds 16'h0F0F; A writes 16'h7777 while B reads addr 2 -> dob=16'h0F0F, collision=1.
- Reset mid-clear: assert rst_n low at clear cycle 8, then release -> init_busy high for a full 16 cycles again, and all addresses read CLEAR_VAL.
